tt_um_kris_serial_adder: RTL

Parametrised bit-serial adder/subtractor for a TinyTapeout tile, the sequential successor to the team's single-bit full-adder tile. Operands of WIDTH bits are loaded from the input switches and summed one bit per clock through a single full-adder slice with a registered carry. The result, carry and signed overflow are latched for display. Optional accumulate mode feeds each result back as the next A operand, giving running sums.

---
 rtl/kris_serial_adder_pkg.sv | 26 ++
 rtl/kris_fa_bit.sv | 17 +
 rtl/tt_um_kris_serial_adder.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/kris_serial_adder_pkg.sv
// Shared definitions for the bit-serial adder tile: FSM state encoding,
// bit positions within the uio bus, and the fixed uio output-enable pattern.
package kris_serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    // uio_in control bits
    localparam int unsigned BIT_LOAD_A = 0;
    localparam int unsigned BIT_LOAD_B = 1;
    localparam int unsigned BIT_START  = 2;
    localparam int unsigned BIT_SUB    = 3;

    // uio_out status bits
    localparam int unsigned BIT_BUSY   = 4;
    localparam int unsigned BIT_DONE   = 5;
    localparam int unsigned BIT_CARRY  = 6;
    localparam int unsigned BIT_OVF    = 7;

    // Upper nibble of uio drives status, lower nibble is input only
    localparam logic [7:0] UIO_OE = 8'hF0;

endpackage

// File: rtl/kris_fa_bit.sv
// Single-bit combinational full adder, the one arithmetic slice of the
// serial adder.
//   a, b, cin : addend bits and carry in
//   s         : sum bit
//   cout      : carry out (majority of the three inputs)
module kris_fa_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/tt_um_kris_serial_adder.sv
// Bit-serial adder/subtractor tile. Operands are loaded from ui_in, then
// summed LSB first through one full-adder slice with a registered carry,
// taking WIDTH cycles. Result, carry and signed overflow are latched for
// display and hold their previous values while an operation runs.
//   clk, rst_n : tile clock, asynchronous active-low reset
//   ena        : tile enable; low freezes every register
//   ui_in      : operand data, bits [WIDTH-1:0] used
//   uio_in     : [0] load_a, [1] load_b, [2] start, [3] sub
//   uo_out     : result, zero-extended above WIDTH
//   uio_out    : [4] busy, [5] done, [6] carry, [7] overflow, [3:0] zero
//   uio_oe     : constant 8'hF0
module tt_um_kris_serial_adder
    import kris_serial_adder_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter bit ACCUMULATE = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t             state, state_next;
    logic [WIDTH-1:0]   a_reg, b_reg;
    logic [WIDTH-1:0]   a_sh, b_sh, res_sh;
    logic [WIDTH-1:0]   result;
    logic [CNT_W-1:0]   bit_cnt;
    logic               sub_reg, carry_reg;
    logic               carry_flag, ovf_flag;

    logic load_a, load_b, start, sub;
    logic accepting, do_load, do_start, last_bit;
    logic fa_b, fa_s, fa_cout;
    logic [WIDTH-1:0] sum_word;
    logic unused_bits;

    assign load_a = uio_in[BIT_LOAD_A];
    assign load_b = uio_in[BIT_LOAD_B];
    assign start  = uio_in[BIT_START];
    assign sub    = uio_in[BIT_SUB];

    // DONE accepts commands exactly like IDLE; a load wins over start
    assign accepting = (state != ADD);
    assign do_load   = accepting && (load_a || load_b);
    assign do_start  = accepting && start && !load_a && !load_b;
    assign last_bit  = (state == ADD) && (bit_cnt == CNT_W'(WIDTH - 1));

    // Subtraction is A + ~B + 1: invert B here, the +1 is the initial carry
    assign fa_b = b_sh[0] ^ sub_reg;

    kris_fa_bit u_fa (
        .a    (a_sh[0]),
        .b    (fa_b),
        .cin  (carry_reg),
        .s    (fa_s),
        .cout (fa_cout)
    );

    // Complete result word including the bit being produced this cycle
    assign sum_word = {fa_s, res_sh[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else if (ena) begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                // A load leaves DONE so the done flag drops
                if (do_load) begin
                    state_next = IDLE;
                end else if (do_start) begin
                    state_next = ADD;
                end
            end
            ADD: begin
                if (last_bit) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg      <= '0;
            b_reg      <= '0;
            a_sh       <= '0;
            b_sh       <= '0;
            res_sh     <= '0;
            result     <= '0;
            bit_cnt    <= '0;
            sub_reg    <= 1'b0;
            carry_reg  <= 1'b0;
            carry_flag <= 1'b0;
            ovf_flag   <= 1'b0;
        end else if (ena) begin
            if (do_load) begin
                if (load_a) begin
                    a_reg <= ui_in[WIDTH-1:0];
                end
                if (load_b) begin
                    b_reg <= ui_in[WIDTH-1:0];
                end
            end

            if (do_start) begin
                a_sh      <= a_reg;
                b_sh      <= b_reg;
                sub_reg   <= sub;
                carry_reg <= sub;
                bit_cnt   <= '0;
            end

            if (state == ADD) begin
                a_sh      <= a_sh >> 1;
                b_sh      <= b_sh >> 1;
                res_sh    <= sum_word;
                carry_reg <= fa_cout;
                bit_cnt   <= bit_cnt + 1'b1;
                if (last_bit) begin
                    result     <= sum_word;
                    carry_flag <= fa_cout;
                    // carry_reg holds the carry into the MSB on this edge
                    ovf_flag   <= carry_reg ^ fa_cout;
                    if (ACCUMULATE) begin
                        a_reg <= sum_word;
                    end
                end
            end
        end
    end

    assign uo_out  = 8'(result);
    assign uio_out = {ovf_flag, carry_flag, (state == DONE), (state == ADD), 4'b0000};
    assign uio_oe  = UIO_OE;

    assign unused_bits = ^{uio_in[7:4], ui_in};

endmodule
